// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 format constants, field widths and field struct
package fp32_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int WORD_W   = SIGN_W + EXP_W + FRAC_W;
  localparam int SIG_W    = FRAC_W + 1;
  localparam int PROD_W   = 2 * SIG_W;
  localparam int EXPI_W   = 10;

  localparam int                FP_BIAS = 127;
  localparam logic [EXP_W-1:0]  EXP_MAX = 8'd255;
  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/floating_point_multiplier_if.sv
// rtl/floating_point_multiplier_if.sv - operand/load/result bundle for the FP multiplier
interface floating_point_multiplier_if;
  import fp32_pkg::*;

  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              loadInReg;
  logic              loadOutReg;
  logic [WORD_W-1:0] c;

  modport master (output a, output b, output loadInReg, output loadOutReg, input c);
  modport slave  (input a, input b, input loadInReg, input loadOutReg, output c);

endinterface

// File: rtl/significand_mult.sv
// rtl/significand_mult.sv - combinational 24x24 unsigned significand multiplier
module significand_mult
  import fp32_pkg::*;
(
  input  logic [SIG_W-1:0]  i_sig_a,
  input  logic [SIG_W-1:0]  i_sig_b,
  output logic [PROD_W-1:0] o_prod
);

  assign o_prod = PROD_W'(i_sig_a) * PROD_W'(i_sig_b);

endmodule

// File: rtl/floating_point_multiplier.sv
// rtl/floating_point_multiplier.sv - registered binary32 multiplier with RNE rounding
module floating_point_multiplier
  import fp32_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RESETn,
  floating_point_multiplier_if.slave  bus
);

  localparam logic signed [EXPI_W-1:0] BIAS_S   = EXPI_W'(FP_BIAS);
  localparam logic signed [EXPI_W-1:0] EXPMAX_S = EXPI_W'(EXP_MAX);

  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic [WORD_W-1:0] r_c;

  fp32_t             w_fa;
  fp32_t             w_fb;
  logic [PROD_W-1:0] w_prod;

  logic                     w_sign;
  logic                     w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic signed [EXPI_W-1:0] w_exp_pre;
  logic signed [EXPI_W-1:0] w_exp_n;
  logic signed [EXPI_W-1:0] w_exp_f;
  logic [SIG_W-1:0]         w_mant;
  logic                     w_g, w_r, w_s;
  logic                     w_round_up;
  logic [SIG_W:0]           w_mant_rnd;
  logic [FRAC_W-1:0]        w_frac_f;
  logic [WORD_W-1:0]        w_result;

  assign w_fa = r_a;
  assign w_fb = r_b;

  significand_mult u_sig_mult (
    .i_sig_a (({1'b1, w_fa.frac})),
    .i_sig_b (({1'b1, w_fb.frac})),
    .o_prod  (w_prod)
  );

  // Operand capture stage
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_a <= '0;
      r_b <= '0;
    end else if (bus.loadInReg) begin
      r_a <= bus.a;
      r_b <= bus.b;
    end
  end

  // Exponent, normalization, round-to-nearest-even and special-case selection
  always_comb begin
    w_sign     = w_fa.sign ^ w_fb.sign;
    w_a_nan    = (w_fa.exp == EXP_MAX) && (w_fa.frac != '0);
    w_b_nan    = (w_fb.exp == EXP_MAX) && (w_fb.frac != '0);
    w_a_inf    = (w_fa.exp == EXP_MAX) && (w_fa.frac == '0);
    w_b_inf    = (w_fb.exp == EXP_MAX) && (w_fb.frac == '0);
    // exp==0 covers both true zero and denormals, which are flushed
    w_a_zero   = (w_fa.exp == '0);
    w_b_zero   = (w_fb.exp == '0);

    w_exp_pre  = $signed({2'b00, w_fa.exp}) + $signed({2'b00, w_fb.exp}) - BIAS_S;

    // Product of two [1,2) significands lies in [1,4); bit 47 means >= 2
    if (w_prod[PROD_W-1]) begin
      w_mant  = w_prod[47:24];
      w_g     = w_prod[23];
      w_r     = w_prod[22];
      w_s     = |w_prod[21:0];
      w_exp_n = w_exp_pre + 10'sd1;
    end else begin
      w_mant  = w_prod[46:23];
      w_g     = w_prod[22];
      w_r     = w_prod[21];
      w_s     = |w_prod[20:0];
      w_exp_n = w_exp_pre;
    end

    w_round_up = w_g & (w_r | w_s | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + (SIG_W+1)'(w_round_up);

    // Rounding carry-out: mantissa became 2.0, renormalize
    if (w_mant_rnd[SIG_W]) begin
      w_frac_f = w_mant_rnd[FRAC_W:1];
      w_exp_f  = w_exp_n + 10'sd1;
    end else begin
      w_frac_f = w_mant_rnd[FRAC_W-1:0];
      w_exp_f  = w_exp_n;
    end

    if (w_a_nan || w_b_nan) begin
      w_result = QNAN;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_result = QNAN;
    end else if (w_a_inf || w_b_inf) begin
      w_result = {w_sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_result = {w_sign, {(WORD_W-1){1'b0}}};
    end else if (w_exp_f >= EXPMAX_S) begin
      w_result = {w_sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (w_exp_f <= 10'sd0) begin
      w_result = {w_sign, {(WORD_W-1){1'b0}}};
    end else begin
      w_result = {w_sign, w_exp_f[EXP_W-1:0], w_frac_f};
    end
  end

  // Result capture stage
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_c <= '0;
    end else if (bus.loadOutReg) begin
      r_c <= w_result;
    end
  end

  assign bus.c = r_c;

endmodule

// File: tb/tb_floating_point_multiplier.sv
// tb/tb_floating_point_multiplier.sv - directed-vector bench for floating_point_multiplier
module tb_floating_point_multiplier;

  logic CLK = 1'b0;
  logic RESETn;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  floating_point_multiplier_if bus ();

  floating_point_multiplier dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic mul2(input logic [31:0] x, input logic [31:0] y);
    @(negedge CLK);
    bus.a = x;
    bus.b = y;
    bus.loadInReg  = 1'b1;
    bus.loadOutReg = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.loadInReg  = 1'b0;
    bus.loadOutReg = 1'b0;
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"two_x_three",   32'h40000000, 32'h40400000, 32'h40C00000};
    vecs[1]  = '{"norm_1p5_sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vecs[2]  = '{"sign_neg",      32'hC0000000, 32'h3F000000, 32'hBF800000};
    vecs[3]  = '{"round_sticky",  32'h3F800001, 32'h3F800001, 32'h3F800002};
    vecs[4]  = '{"overflow",      32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[5]  = '{"denorm_b",      32'h00800003, 32'h00400002, 32'h00000000};
    vecs[6]  = '{"underflow",     32'h00800000, 32'h00800000, 32'h00000000};
    vecs[7]  = '{"inf_x_zero",    32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[8]  = '{"neg_inf",       32'hFF800000, 32'h40000000, 32'hFF800000};
    vecs[9]  = '{"nan_in",        32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[10] = '{"neg_zero",      32'h80000000, 32'h40000000, 32'h80000000};

    RESETn         = 1'b0;
    bus.a          = 32'h0;
    bus.b          = 32'h0;
    bus.loadInReg  = 1'b0;
    bus.loadOutReg = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("reset_c", bus.c, 32'h00000000);
    RESETn = 1'b1;

    foreach (vecs[i]) begin
      mul2(vecs[i].a, vecs[i].b);
      check(vecs[i].tag, bus.c, vecs[i].c);
    end

    mul2(32'h40000000, 32'h40400000);
    check("reload_six", bus.c, 32'h40C00000);

    bus.a = 32'h3FC00000;
    bus.b = 32'h3FC00000;
    bus.loadInReg = 1'b1;
    @(negedge CLK);
    bus.loadInReg = 1'b0;
    check("load_in_only_hold", bus.c, 32'h40C00000);

    bus.loadOutReg = 1'b1;
    @(negedge CLK);
    bus.loadOutReg = 1'b0;
    check("load_out_only", bus.c, 32'h40100000);

    bus.a = 32'h7F800000;
    bus.b = 32'h00000000;
    @(negedge CLK);
    @(negedge CLK);
    check("no_load_hold", bus.c, 32'h40100000);

    bus.a = 32'hC0000000;
    bus.b = 32'h3F000000;
    bus.loadInReg = 1'b1;
    @(negedge CLK);
    bus.a = 32'h40000000;
    bus.b = 32'h40400000;
    bus.loadOutReg = 1'b1;
    @(negedge CLK);
    check("same_edge_old_ops", bus.c, 32'hBF800000);
    @(negedge CLK);
    bus.loadInReg  = 1'b0;
    bus.loadOutReg = 1'b0;
    check("second_edge_new", bus.c, 32'h40C00000);

    bus.a = 32'h3F800001;
    bus.b = 32'h3F800001;
    bus.loadInReg = 1'b1;
    @(negedge CLK);
    bus.loadInReg  = 1'b0;
    bus.loadOutReg = 1'b1;
    @(negedge CLK);
    bus.loadOutReg = 1'b0;
    check("pipelined_latency", bus.c, 32'h3F800002);

    bus.a = 32'h40000000;
    bus.b = 32'h40400000;
    bus.loadInReg  = 1'b1;
    bus.loadOutReg = 1'b1;
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    bus.loadInReg = 1'b0;
    check("reset_over_loads", bus.c, 32'h00000000);
    @(negedge CLK);
    bus.loadOutReg = 1'b0;
    check("reset_clears_ops", bus.c, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/floating_point_multiplier.md
# floating_point_multiplier

Single-precision (IEEE-754 binary32) floating-point multiplier with a registered operand stage and a registered result stage, each with its own load enable. It sits in the datapath as a two-register pipelined FP multiply unit: operands are captured on `loadInReg`, the product is computed combinationally from the captured operands, and the result is captured on `loadOutReg`.

## Interface
- No parameters; format fixed to binary32 (1 sign, 8 exponent with bias 127, 23 fraction).
- `CLK` input, 1 bit: rising-edge clock.
- `RESETn` input, 1 bit: reset is synchronous and active-low.
- `a` input, 32 bits: operand A.
- `b` input, 32 bits: operand B.
- `loadInReg` input, 1 bit: capture `a`, `b` into the operand registers.
- `loadOutReg` input, 1 bit: capture the current product into the result register.
- `c` output, 32 bits: result register.

## Operation
- Reset: if `RESETn`=0 at a rising edge, the operand registers and `c` are set to 0x00000000. Reset overrides both loads.
- Operand stage: when `loadInReg`=1, `ra`←`a` and `rb`←`b`. Otherwise they hold.
- Product is combinational from `ra` and `rb`:
  - sign = `ra[31]` ^ `rb[31]`.
  - Significands are {1,frac}, giving a 24×24 → 48-bit product.
  - exponent = eA + eB − 127, computed in at least 10 bits signed.
  - If product bit 47 is set, shift right by one and increment the exponent.
- Rounding: round-to-nearest-even on the 24-bit mantissa using guard, round and sticky bits. A rounding carry-out renormalizes and increments the exponent.
- Special cases, in priority order:
  1. Either operand NaN (exp=255, frac≠0) → canonical NaN 0x7FC00000.
  2. Inf × zero → 0x7FC00000.
  3. Either operand Inf → ±Inf (sign rule applies).
  4. Either operand zero or denormal (exp=0) → ±0. Denormal inputs are flushed to zero.
- Overflow: a final biased exponent ≥255 gives ±Inf (exp=255, frac=0).
- Underflow: a final biased exponent ≤0 gives ±0. There are no denormal outputs.
- Result stage: when `loadOutReg`=1, `c`←product. Otherwise `c` holds.

## Timing
- Latency: `a`/`b` to `c` is two rising edges when `loadInReg` and `loadOutReg` are pulsed on successive edges.
- When both loads are high on the same edge, `c` captures the product of the *previous* `ra`/`rb`, i.e. the values before that edge.
  - Holding both loads high for two consecutive edges yields the new product after the second edge.
- Loads are level-sensitive per edge; there is no handshake.
- Outputs change only at rising edges. No combinational path exists from any input to `c`.
- Reset in mid-operation discards the pending operands and result.

## Structure
- Shared package `fp32_pkg`:
  - constants: `FP_BIAS`=127, `EXP_MAX`=255, `QNAN`=32'h7FC00000;
  - field widths;
  - a packed struct typedef {sign, exp[7:0], frac[22:0]}.
- Sub-module `significand_mult`: a purely combinational 24×24→48 unsigned multiplier.
- The top level contains the registers, exponent logic, normalization, rounding and special-case muxing.

## Test plan
- Basic product: reset, then `a`=0x40000000 (2.0), `b`=0x40400000 (3.0). Assert both loads for two edges → `c`=0x40C00000 (6.0).
- Normalization and sign: 0x3FC00000×0x3FC00000 → `c`=0x40100000 (2.25). 0xC0000000×0x3F000000 → `c`=0xBF800000 (−1.0).
- Rounding: 0x3F800001×0x3F800001 → `c`=0x3F800002 (nearest-even, sticky set).
- Overflow, underflow and denormal:
  - 0x7F000000×0x7F000000 → `c`=0x7F800000.
  - 0x00800003×0x00400002 (denormal B) → `c`=0x00000000.
  - 0x00800000×0x00800000 → `c`=0x00000000.
- Specials: 0x7F800000×0x00000000 → 0x7FC00000. 0xFF800000×0x40000000 → 0xFF800000. 0x7FC00001×0x3F800000 → 0x7FC00000.
- Control:
  - With only `loadInReg` pulsed, `c` holds its old value.
  - With only `loadOutReg` pulsed, `c` takes the product of the held operands.
  - With `RESETn`=0 while both loads are high, `c`=0 after the edge.
  - Changing `a`/`b` without a load leaves `c` unchanged.
